pixel_stream_framer: RTL and testbench
======================================

// Module: pixel_stream_framer
// PURPOSE
//  Tags a raw stream of pixel colours with raster coordinates and frame/line markers.
//  Output is a valid/ready video stream for the frame-buffer writer and overlay stages.
//  Generalises the single-pixel enable-driven coordinate generator:
//   - adds backpressure;
//   - handles PPB pixels per beat;
//   - selects top-down or bottom-up scan;
//   - emits SOF/EOL/EOF and a frame counter.
// PARAMETERS
//  RGB_SIZE       24   bits per pixel colour
//  SCREEN_WIDTH   640  active pixels per line; must be a multiple of PPB
//  SCREEN_HEIGHT  480  active lines per frame
//  PPB            1    pixels per beat (1, 2 or 4)
//  COORD_W        16   width of x/y coordinate outputs; must hold max(W,H)-1
// PORTS
//  clk          in   1             clock, all logic on rising edge
//  reset        in   1             synchronous, active-high
//  s_valid      in   1             input beat valid
//  s_ready      out  1             input beat accepted when s_valid && s_ready
//  s_data       in   PPB*RGB_SIZE  colours; pixel k in bits [k*RGB_SIZE +: RGB_SIZE], k=0 leftmost
//  y_flip       in   1             0: y counts 0..H-1; 1: y counts H-1..0; sampled at frame start only
//  m_valid      out  1             output beat valid
//  m_ready      in   1             downstream accepts when m_valid && m_ready
//  m_data       out  PPB*RGB_SIZE  colours, same packing as s_data
//  m_x          out  COORD_W       x of pixel 0 in beat (multiple of PPB)
//  m_y          out  COORD_W       y of the beat's line
//  m_sof        out  1             first beat of frame (x==0, y==start line)
//  m_eol        out  1             last beat of line (x==W-PPB)
//  m_eof        out  1             last beat of frame (eol on end line)
//  frame_count  out  16            completed frames, increments on the EOF handshake, wraps at 0xFFFF
// BEHAVIOUR
//  - Reset: m_valid=0; m_data, m_x, m_y, m_sof, m_eol, m_eof = 0; frame_count=0.
//    Raster counters go to frame start: x=0, y=0. Latched flip=0. s_ready=1 in the first cycle after reset.
//  - Reset mid-frame discards the partial frame and any held output beat. The next accepted beat is SOF.
//  - Pipeline: one output register stage, latency 1 cycle from input handshake to m_valid.
//  - s_ready = !m_valid || m_ready (combinational), giving full throughput of one beat per clock.
//  - On input handshake, the output register loads s_data and the current x/y and marker flags.
//    m_valid is then set and the raster counter advances.
//  - If m_valid && !m_ready, all m_* outputs hold stable and no input is accepted.
//  - If the input handshake and output handshake coincide, the register reloads in the same cycle.
//  - Raster counter advance:
//     - x += PPB;
//     - if x==W-PPB: x wraps to 0 and y steps (+1, or -1 when flipped);
//     - if also on the end line (H-1, or 0 when flipped): y reloads to the start line;
//     - start line is taken from y_flip as sampled at that instant (0 if y_flip=0, H-1 if y_flip=1).
//  - y_flip changes mid-frame have no effect until the next frame start. The first frame after reset samples y_flip on its first beat.
//  - When PPB==W, every beat is eol. When H==1, every eol is also eof and sof follows.
//  - Coordinate arithmetic is unsigned COORD_W. Comparisons use the parameter constants, no dynamic widths.
// STRUCTURE
//  - Shared package video_pkg:
//     - rgb_t (logic [RGB_SIZE-1:0]);
//     - coord_t (logic [COORD_W-1:0]);
//     - default SCREEN_WIDTH/SCREEN_HEIGHT constants.
//  - Sub-module raster_counter owns the x/y counters, flip latch and marker decode:
//     - inputs: step, y_flip;
//     - outputs: x, y, sof, eol, eof.
//  - Top level holds the handshake, output register and frame_count.
// TESTING
//  - Reset then 640*480 beats, s_valid=1, m_ready=1, PPB=1:
//    first beat sof, x=0, y=0; beat 640 eol, x=639;
//    last beat eof, x=639, y=479; frame_count=1; next beat sof, y=0.
//  - y_flip=1 at frame start: first beat y=479, sof;
//    y_flip toggled to 0 mid-frame -> frame still ends at y=0 with eof;
//    next frame starts at y=0.
//  - Backpressure: m_ready low 5 cycles at x=100 -> m_x/m_data held at 100, s_ready=0;
//    release -> x=101 next, no beat lost or duplicated.
//  - PPB=4, W=16, H=2: m_x sequence 0,4,8,12 with eol on 12; y 0 then 1; eof on the 8th beat.
//  - Reset asserted at x=300, y=20 with m_valid=1 -> next cycle m_valid=0;
//    next accepted beat sof, x=0, y=0; frame_count=0.
//  - Random s_valid/m_ready over 3 frames -> scoreboard matches data order and coordinates; frame_count=3.

Source files
------------

// File: rtl/pixel_stream_framer_pkg.sv
// Shared video types and default raster geometry for the pixel stream framer.
package video_pkg;

  localparam int DEFAULT_RGB_SIZE      = 24;
  localparam int DEFAULT_COORD_W       = 16;
  localparam int DEFAULT_SCREEN_WIDTH  = 640;
  localparam int DEFAULT_SCREEN_HEIGHT = 480;
  localparam int FRAME_COUNT_W         = 16;

  typedef logic [DEFAULT_RGB_SIZE-1:0] rgb_t;
  typedef logic [DEFAULT_COORD_W-1:0]  coord_t;
  typedef logic [FRAME_COUNT_W-1:0]    frame_count_t;

endpackage

// File: rtl/pixel_stream_framer_if.sv
// Valid/ready pixel stream; master drives the tagged stream, slave is a raw colour input.
interface pixel_stream_framer_if #(
  parameter int RGB_SIZE = 24,
  parameter int PPB      = 1,
  parameter int COORD_W  = 16
);

  logic                    valid;
  logic                    ready;
  logic [PPB*RGB_SIZE-1:0] data;
  logic [COORD_W-1:0]      x;
  logic [COORD_W-1:0]      y;
  logic                    sof;
  logic                    eol;
  logic                    eof;

  modport master (
    output valid, data, x, y, sof, eol, eof,
    input  ready
  );

  // Raw colour input: coordinates and markers are generated, never received.
  modport slave (
    input  valid, data,
    output ready
  );

endinterface

// File: rtl/pixel_stream_framer_raster_counter.sv
// Raster x/y counters with per-frame scan-direction latch and SOF/EOL/EOF decode.
module raster_counter
  import video_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int PPB           = 1,
  parameter int COORD_W       = DEFAULT_COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               y_flip,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               sof,
  output logic               eol,
  output logic               eof
);

  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(SCREEN_WIDTH - PPB);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(SCREEN_HEIGHT - 1);
  localparam logic [COORD_W-1:0] X_STEP     = COORD_W'(PPB);
  localparam logic [COORD_W-1:0] Y_ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] COORD_ZERO = COORD_W'(0);

  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;
  logic               flip_r;
  logic               first_r;
  logic [COORD_W-1:0] y_s;
  logic               flip_s;
  logic               end_line_s;

  // After reset no frame start has been seen yet, so y_flip is taken live on the first beat.
  always_comb begin
    flip_s = flip_r;
    y_s    = y_r;
    if (first_r) begin
      flip_s = y_flip;
      y_s    = y_flip ? Y_LAST : COORD_ZERO;
    end else begin
      flip_s = flip_r;
      y_s    = y_r;
    end
  end

  assign end_line_s = flip_s ? (y_s == COORD_ZERO) : (y_s == Y_LAST);
  assign eol        = (x_r == X_LAST);
  assign eof        = eol && end_line_s;
  assign sof        = (x_r == COORD_ZERO) && (y_s == (flip_s ? Y_LAST : COORD_ZERO));
  assign x          = x_r;
  assign y          = y_s;

  // Advance one beat; at end of frame the start line and direction come from y_flip now.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r     <= COORD_ZERO;
      y_r     <= COORD_ZERO;
      flip_r  <= 1'b0;
      first_r <= 1'b1;
    end else if (step) begin
      first_r <= 1'b0;
      if (eol) begin
        x_r <= COORD_ZERO;
        if (end_line_s) begin
          y_r    <= y_flip ? Y_LAST : COORD_ZERO;
          flip_r <= y_flip;
        end else begin
          y_r    <= flip_s ? (y_s - Y_ONE) : (y_s + Y_ONE);
          flip_r <= flip_s;
        end
      end else begin
        x_r    <= x_r + X_STEP;
        y_r    <= y_s;
        flip_r <= flip_s;
      end
    end
  end

endmodule

// File: rtl/pixel_stream_framer.sv
// Tags a raw pixel stream with raster coordinates and frame/line markers behind one
// output register stage with full-throughput valid/ready handshaking.
module pixel_stream_framer
  import video_pkg::*;
#(
  parameter int RGB_SIZE      = DEFAULT_RGB_SIZE,
  parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int PPB           = 1,
  parameter int COORD_W       = DEFAULT_COORD_W
) (
  input  logic                  clk,
  input  logic                  reset,
  pixel_stream_framer_if.slave  s,
  input  logic                  y_flip,
  pixel_stream_framer_if.master m,
  output frame_count_t          frame_count
);

  logic [PPB*RGB_SIZE-1:0] data_r;
  logic [COORD_W-1:0]      x_r;
  logic [COORD_W-1:0]      y_r;
  logic                    valid_r;
  logic                    sof_r;
  logic                    eol_r;
  logic                    eof_r;
  frame_count_t            frame_count_r;

  logic                    ready_s;
  logic                    take_s;
  logic [COORD_W-1:0]      x_s;
  logic [COORD_W-1:0]      y_s;
  logic                    sof_s;
  logic                    eol_s;
  logic                    eof_s;

  assign ready_s = !valid_r || m.ready;
  assign take_s  = s.valid && ready_s;

  raster_counter #(
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT),
    .PPB           (PPB),
    .COORD_W       (COORD_W)
  ) u_raster_counter (
    .clk    (clk),
    .reset  (reset),
    .step   (take_s),
    .y_flip (y_flip),
    .x      (x_s),
    .y      (y_s),
    .sof    (sof_s),
    .eol    (eol_s),
    .eof    (eof_s)
  );

  // Output register: reload on every accepted input beat, drop valid once drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      x_r     <= COORD_W'(0);
      y_r     <= COORD_W'(0);
      sof_r   <= 1'b0;
      eol_r   <= 1'b0;
      eof_r   <= 1'b0;
    end else if (take_s) begin
      valid_r <= 1'b1;
      data_r  <= s.data;
      x_r     <= x_s;
      y_r     <= y_s;
      sof_r   <= sof_s;
      eol_r   <= eol_s;
      eof_r   <= eof_s;
    end else if (m.ready) begin
      valid_r <= 1'b0;
    end
  end

  // A frame counts as completed only when its EOF beat is handed downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_r <= 16'd0;
    end else if (valid_r && m.ready && eof_r) begin
      frame_count_r <= frame_count_r + 16'd1;
    end
  end

  assign s.ready     = ready_s;
  assign m.valid     = valid_r;
  assign m.data      = data_r;
  assign m.x         = x_r;
  assign m.y         = y_r;
  assign m.sof       = sof_r;
  assign m.eol       = eol_r;
  assign m.eof       = eof_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Directed and randomised-handshake checks of pixel_stream_framer on three geometries.
module tb_pixel_stream_framer;

  localparam int A_W = 640;
  localparam int A_H = 24;
  localparam int B_W = 16;
  localparam int B_H = 2;
  localparam int C_W = 10;
  localparam int C_H = 3;
  localparam int C_TOTAL = 3 * (C_W / 2) * C_H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_flip, b_flip, c_flip;
  logic [15:0] a_fc, b_fc, c_fc;
  int          tests = 0;
  int          fails = 0;

  pixel_stream_framer_if #(.RGB_SIZE(24), .PPB(1), .COORD_W(16)) a_s (), a_m ();
  pixel_stream_framer_if #(.RGB_SIZE(24), .PPB(4), .COORD_W(16)) b_s (), b_m ();
  pixel_stream_framer_if #(.RGB_SIZE(8),  .PPB(2), .COORD_W(16)) c_s (), c_m ();

  pixel_stream_framer #(.RGB_SIZE(24), .SCREEN_WIDTH(A_W), .SCREEN_HEIGHT(A_H), .PPB(1), .COORD_W(16))
    dut_a (.clk(clk), .reset(reset), .s(a_s), .y_flip(a_flip), .m(a_m), .frame_count(a_fc));
  pixel_stream_framer #(.RGB_SIZE(24), .SCREEN_WIDTH(B_W), .SCREEN_HEIGHT(B_H), .PPB(4), .COORD_W(16))
    dut_b (.clk(clk), .reset(reset), .s(b_s), .y_flip(b_flip), .m(b_m), .frame_count(b_fc));
  pixel_stream_framer #(.RGB_SIZE(8), .SCREEN_WIDTH(C_W), .SCREEN_HEIGHT(C_H), .PPB(2), .COORD_W(16))
    dut_c (.clk(clk), .reset(reset), .s(c_s), .y_flip(c_flip), .m(c_m), .frame_count(c_fc));

  task automatic do_reset;
    reset = 1'b1;
    a_s.valid = 1'b0;
    b_s.valid = 1'b0;
    c_s.valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    a_m.ready = 1'b0;
    #1;
    tests++;
    if ({a_m.valid, a_m.x, a_m.y, a_m.sof, a_m.eol, a_m.eof, a_m.data} !== 60'd0) begin
      fails++;
      $display("FAIL reset_a_outputs: got %h expected 0", {a_m.valid, a_m.x, a_m.y, a_m.sof, a_m.eol, a_m.eof, a_m.data});
    end
    tests++;
    if (a_fc !== 16'd0) begin fails++; $display("FAIL reset_frame_count: got %0d expected 0", a_fc); end
    tests++;
    if (a_s.ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b expected 1", a_s.ready); end
    tests++;
    if ({b_m.valid, c_m.valid, b_fc, c_fc} !== 34'd0) begin
      fails++;
      $display("FAIL reset_b_c: got %h expected 0", {b_m.valid, c_m.valid, b_fc, c_fc});
    end
  endtask

  task automatic test_full_frame;
    int n_beats = A_W * A_H;
    logic [59:0] got, exp;
    do_reset();
    a_flip = 1'b0;
    a_m.ready = 1'b1;
    a_s.valid = 1'b1;
    a_s.data = 24'd0;
    for (int n = 0; n <= n_beats; n++) begin
      @(negedge clk);
      got = {a_m.valid, a_m.x, a_m.y, a_m.sof, a_m.eol, a_m.eof, a_m.data};
      exp = {1'b1, 16'(n % A_W), 16'((n / A_W) % A_H), (n % n_beats) == 0,
             (n % A_W) == A_W - 1, (n % n_beats) == n_beats - 1, 24'(n)};
      tests++;
      if (got !== exp) begin fails++; $display("FAIL full_frame beat %0d: got %h expected %h", n, got, exp); end
      if (n == n_beats - 1) begin
        tests++;
        if (a_fc !== 16'd0) begin fails++; $display("FAIL full_frame_fc_before_eof: got %0d expected 0", a_fc); end
      end
      if (n == n_beats) begin
        tests++;
        if (a_fc !== 16'd1) begin fails++; $display("FAIL full_frame_fc: got %0d expected 1", a_fc); end
      end
      a_s.data = 24'(n + 1);
    end
    a_s.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flip;
    int n_beats = A_W * A_H;
    logic [59:0] got, exp;
    do_reset();
    a_flip = 1'b1;
    a_m.ready = 1'b1;
    a_s.valid = 1'b1;
    a_s.data = 24'd0;
    for (int n = 0; n <= n_beats; n++) begin
      @(negedge clk);
      got = {a_m.valid, a_m.x, a_m.y, a_m.sof, a_m.eol, a_m.eof, a_m.data};
      exp = {1'b1, 16'(n % A_W), (n == n_beats) ? 16'd0 : 16'(A_H - 1 - n / A_W), (n % n_beats) == 0,
             (n % A_W) == A_W - 1, n == n_beats - 1, 24'(n)};
      tests++;
      if (got !== exp) begin fails++; $display("FAIL flip beat %0d: got %h expected %h", n, got, exp); end
      if (n == A_W * 5) a_flip = 1'b0;
      a_s.data = 24'(n + 1);
    end
    tests++;
    if (a_fc !== 16'd1) begin fails++; $display("FAIL flip_fc: got %0d expected 1", a_fc); end
    a_s.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    do_reset();
    a_flip = 1'b0;
    a_m.ready = 1'b1;
    a_s.valid = 1'b1;
    a_s.data = 24'd0;
    for (int n = 0; n <= 100; n++) begin
      @(negedge clk);
      tests++;
      if ({a_m.x, a_m.data} !== {16'(n), 24'(n)}) begin
        fails++;
        $display("FAIL bp_lead beat %0d: got x=%0d data=%0d", n, a_m.x, a_m.data);
      end
      a_s.data = 24'(n + 1);
    end
    a_m.ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if ({a_m.valid, a_m.x, a_m.data, a_s.ready} !== {1'b1, 16'd100, 24'd100, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: got valid=%b x=%0d data=%0d s_ready=%b expected 1 100 100 0",
                 c, a_m.valid, a_m.x, a_m.data, a_s.ready);
      end
    end
    a_m.ready = 1'b1;
    for (int n = 101; n <= 102; n++) begin
      @(negedge clk);
      tests++;
      if ({a_m.valid, a_m.x, a_m.data} !== {1'b1, 16'(n), 24'(n)}) begin
        fails++;
        $display("FAIL bp_release beat %0d: got x=%0d data=%0d", n, a_m.x, a_m.data);
      end
      a_s.data = 24'(n + 1);
    end
    a_s.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int target = 20 * A_W + 300;
    do_reset();
    a_flip = 1'b0;
    a_m.ready = 1'b1;
    a_s.valid = 1'b1;
    a_s.data = 24'd0;
    for (int n = 0; n <= target; n++) begin
      @(negedge clk);
      a_s.data = 24'(n + 1);
    end
    tests++;
    if ({a_m.valid, a_m.x, a_m.y} !== {1'b1, 16'd300, 16'd20}) begin
      fails++;
      $display("FAIL mid_reset_pre: got valid=%b x=%0d y=%0d expected 1 300 20", a_m.valid, a_m.x, a_m.y);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_m.valid, a_m.x, a_m.y, a_m.sof, a_m.eol, a_m.eof, a_m.data, a_fc} !== 76'd0) begin
      fails++;
      $display("FAIL mid_reset_clear: got valid=%b x=%0d y=%0d fc=%0d expected all 0", a_m.valid, a_m.x, a_m.y, a_fc);
    end
    reset = 1'b0;
    a_s.data = 24'hABCDEF;
    @(negedge clk);
    tests++;
    if ({a_m.valid, a_m.sof, a_m.x, a_m.y, a_m.data, a_fc} !== {1'b1, 1'b1, 16'd0, 16'd0, 24'hABCDEF, 16'd0}) begin
      fails++;
      $display("FAIL mid_reset_next: got valid=%b sof=%b x=%0d y=%0d data=%h fc=%0d", a_m.valid, a_m.sof, a_m.x, a_m.y, a_m.data, a_fc);
    end
    a_s.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ppb4;
    logic [95:0]  pix;
    logic [131:0] got, exp;
    do_reset();
    b_flip = 1'b0;
    b_m.ready = 1'b1;
    b_s.valid = 1'b1;
    for (int k = 0; k < 4; k++) pix[k*24 +: 24] = 24'(k);
    b_s.data = pix;
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) pix[k*24 +: 24] = 24'((n % 8) * 4 + k);
      got = {b_m.valid, b_m.x, b_m.y, b_m.sof, b_m.eol, b_m.eof, b_m.data};
      exp = {1'b1, 16'((n % 4) * 4), 16'((n / 4) % B_H), (n % 8) == 0, (n % 4) == 3, n == 7, pix};
      tests++;
      if (got !== exp) begin fails++; $display("FAIL ppb4 beat %0d: got %h expected %h", n, got, exp); end
      for (int k = 0; k < 4; k++) pix[k*24 +: 24] = 24'(((n + 1) % 8) * 4 + k);
      b_s.data = pix;
    end
    tests++;
    if (b_fc !== 16'd1) begin fails++; $display("FAIL ppb4_fc: got %0d expected 1", b_fc); end
    b_s.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic [50:0] got, exp;
    do_reset();
    c_flip = 1'b0;
    while (recv < C_TOTAL && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      c_m.ready = 1'($urandom_range(0, 1));
      c_s.valid = (sent < C_TOTAL) && ($urandom_range(0, 1) == 1);
      c_s.data = {8'(sent * 2 + 1), 8'(sent * 2)};
      #1;
      if (c_m.valid && c_m.ready) begin
        got = {c_m.x, c_m.y, c_m.sof, c_m.eol, c_m.eof, c_m.data};
        exp = {16'((recv % 5) * 2), 16'((recv / 5) % C_H), (recv % 15) == 0, (recv % 5) == 4,
               (recv % 15) == 14, 8'(recv * 2 + 1), 8'(recv * 2)};
        tests++;
        if (got !== exp) begin fails++; $display("FAIL random beat %0d: got %h expected %h", recv, got, exp); end
        recv++;
      end
      if (c_s.valid && c_s.ready) sent++;
    end
    tests++;
    if (recv != C_TOTAL) begin fails++; $display("FAIL random_timeout: got %0d beats expected %0d", recv, C_TOTAL); end
    c_s.valid = 1'b0;
    c_m.ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({c_fc, c_m.valid} !== {16'd3, 1'b0}) begin
      fails++;
      $display("FAIL random_fc: got fc=%0d valid=%b expected 3 0", c_fc, c_m.valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_flip = 1'b0; b_flip = 1'b0; c_flip = 1'b0;
    a_s.valid = 1'b0; a_s.data = '0; a_m.ready = 1'b0;
    b_s.valid = 1'b0; b_s.data = '0; b_m.ready = 1'b0;
    c_s.valid = 1'b0; c_s.data = '0; c_m.ready = 1'b0;
    test_reset();
    test_full_frame();
    test_flip();
    test_backpressure();
    test_reset_mid();
    test_ppb4();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
